// File: rtl/display_cfg_axil_master.sv
// display_cfg_axil_master: AXI4-Lite initiator for the display register map.
// One command in flight; a watchdog reports a stalled slave and drains it.
module display_cfg_axil_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_timeout,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] m_awaddr,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [31:0]           m_wdata,
   output logic [3:0]            m_wstrb,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [1:0]            m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [31:0]           m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rvalid,
   output logic                  m_rready
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ?
                       $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] WD_LAST =
      CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP,
      RSP,
      ORPHAN
   } state_t;

   state_t                state_q;
   logic                  wr_q;
   logic                  aw_done_q;
   logic                  w_done_q;
   logic                  slv_done_q;
   logic                  rsp_done_q;
   logic [CW-1:0]         wd_q;
   logic [CW-1:0]         wd_d;
   logic [ADDR_WIDTH-1:0] m_awaddr_q;
   logic                  m_awvalid_q;
   logic [31:0]           m_wdata_q;
   logic [3:0]            m_wstrb_q;
   logic                  m_wvalid_q;
   logic                  m_bready_q;
   logic [ADDR_WIDTH-1:0] m_araddr_q;
   logic                  m_arvalid_q;
   logic                  m_rready_q;
   logic                  rsp_valid_q;
   logic [31:0]           rsp_rdata_q;
   logic [1:0]            rsp_resp_q;
   logic                  rsp_timeout_q;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
   logic wr_addr_done;
   logic wd_exp;

   assign aw_hs  = m_awvalid_q & m_awready;
   assign w_hs   = m_wvalid_q & m_wready;
   assign b_hs   = m_bready_q & m_bvalid;
   assign ar_hs  = m_arvalid_q & m_arready;
   assign r_hs   = m_rready_q & m_rvalid;
   assign rsp_hs = rsp_valid_q & rsp_ready;

   assign wr_addr_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);

   assign wd_d   = (wd_q != WD_MAX) ? wd_q + 1'b1 : wd_q;
   assign wd_exp = WD_EN && (wd_q == WD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         wr_q          <= 1'b0;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         slv_done_q    <= 1'b0;
         rsp_done_q    <= 1'b0;
         wd_q          <= '0;
         m_awaddr_q    <= '0;
         m_awvalid_q   <= 1'b0;
         m_wdata_q     <= '0;
         m_wstrb_q     <= '0;
         m_wvalid_q    <= 1'b0;
         m_bready_q    <= 1'b0;
         m_araddr_q    <= '0;
         m_arvalid_q   <= 1'b0;
         m_rready_q    <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  wr_q       <= cmd_write;
                  aw_done_q  <= 1'b0;
                  w_done_q   <= 1'b0;
                  slv_done_q <= 1'b0;
                  rsp_done_q <= 1'b0;
                  wd_q       <= '0;
                  if (cmd_write) begin
                     m_awaddr_q  <= cmd_addr;
                     m_wdata_q   <= cmd_wdata;
                     m_wstrb_q   <= cmd_wstrb;
                     m_awvalid_q <= 1'b1;
                     m_wvalid_q  <= 1'b1;
                     state_q     <= WR_REQ;
                  end else begin
                     m_araddr_q  <= cmd_addr;
                     m_arvalid_q <= 1'b1;
                     state_q     <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               wd_q <= wd_d;
               if (aw_hs) begin
                  m_awvalid_q <= 1'b0;
                  aw_done_q   <= 1'b1;
               end
               if (w_hs) begin
                  m_wvalid_q <= 1'b0;
                  w_done_q   <= 1'b1;
               end
               if (wd_exp) begin
                  m_bready_q    <= wr_addr_done;
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= '0;
                  rsp_resp_q    <= 2'b10;
                  rsp_timeout_q <= 1'b1;
                  state_q       <= ORPHAN;
               end else if (wr_addr_done) begin
                  m_bready_q <= 1'b1;
                  state_q    <= WR_RESP;
               end
            end
            WR_RESP: begin
               wd_q <= wd_d;
               if (b_hs) begin
                  m_bready_q    <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= '0;
                  rsp_resp_q    <= m_bresp;
                  rsp_timeout_q <= 1'b0;
                  state_q       <= RSP;
               end else if (wd_exp) begin
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= '0;
                  rsp_resp_q    <= 2'b10;
                  rsp_timeout_q <= 1'b1;
                  state_q       <= ORPHAN;
               end
            end
            RD_REQ: begin
               wd_q <= wd_d;
               if (ar_hs) begin
                  m_arvalid_q <= 1'b0;
                  m_rready_q  <= 1'b1;
               end
               if (wd_exp) begin
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= '0;
                  rsp_resp_q    <= 2'b10;
                  rsp_timeout_q <= 1'b1;
                  state_q       <= ORPHAN;
               end else if (ar_hs) begin
                  state_q <= RD_RESP;
               end
            end
            RD_RESP: begin
               wd_q <= wd_d;
               if (r_hs) begin
                  m_rready_q    <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= m_rdata;
                  rsp_resp_q    <= m_rresp;
                  rsp_timeout_q <= 1'b0;
                  state_q       <= RSP;
               end else if (wd_exp) begin
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= '0;
                  rsp_resp_q    <= 2'b10;
                  rsp_timeout_q <= 1'b1;
                  state_q       <= ORPHAN;
               end
            end
            RSP: begin
               if (rsp_hs) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            ORPHAN: begin
               // Drain the slave and drop its response; the timeout is already reported.
               if (aw_hs) begin
                  m_awvalid_q <= 1'b0;
                  aw_done_q   <= 1'b1;
               end
               if (w_hs) begin
                  m_wvalid_q <= 1'b0;
                  w_done_q   <= 1'b1;
               end
               if (ar_hs) begin
                  m_arvalid_q <= 1'b0;
                  m_rready_q  <= 1'b1;
               end
               if (r_hs) begin
                  m_rready_q <= 1'b0;
                  slv_done_q <= 1'b1;
               end
               if (b_hs) begin
                  m_bready_q <= 1'b0;
                  slv_done_q <= 1'b1;
               end else if (wr_q && wr_addr_done && !slv_done_q) begin
                  m_bready_q <= 1'b1;
               end
               if (rsp_hs) begin
                  rsp_valid_q <= 1'b0;
                  rsp_done_q  <= 1'b1;
               end
               if ((slv_done_q | b_hs | r_hs) &&
                   (rsp_done_q | rsp_hs)) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign m_awaddr    = m_awaddr_q;
   assign m_awvalid   = m_awvalid_q;
   assign m_wdata     = m_wdata_q;
   assign m_wstrb     = m_wstrb_q;
   assign m_wvalid    = m_wvalid_q;
   assign m_bready    = m_bready_q;
   assign m_araddr    = m_araddr_q;
   assign m_arvalid   = m_arvalid_q;
   assign m_rready    = m_rready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_resp    = rsp_resp_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_display_cfg_axil_master.sv
// tb_display_cfg_axil_master: directed bench with a response scoreboard.
// The slave side is driven step by step from the main sequence.
module tb_display_cfg_axil_master;

   localparam int AW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [31:0]   cmd_wdata = '0;
   logic [3:0]    cmd_wstrb = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          rsp_timeout;
   logic          busy;
   logic [AW-1:0] m_awaddr;
   logic          m_awvalid;
   logic          m_awready = 1'b0;
   logic [31:0]   m_wdata;
   logic [3:0]    m_wstrb;
   logic          m_wvalid;
   logic          m_wready = 1'b0;
   logic [1:0]    m_bresp = '0;
   logic          m_bvalid = 1'b0;
   logic          m_bready;
   logic [AW-1:0] m_araddr;
   logic          m_arvalid;
   logic          m_arready = 1'b0;
   logic [31:0]   m_rdata = '0;
   logic [1:0]    m_rresp = '0;
   logic          m_rvalid = 1'b0;
   logic          m_rready;

   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        tmo;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   display_cfg_axil_master #(
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .cmd_wstrb  (cmd_wstrb),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_resp   (rsp_resp),
      .rsp_timeout(rsp_timeout),
      .busy       (busy),
      .m_awaddr   (m_awaddr),
      .m_awvalid  (m_awvalid),
      .m_awready  (m_awready),
      .m_wdata    (m_wdata),
      .m_wstrb    (m_wstrb),
      .m_wvalid   (m_wvalid),
      .m_wready   (m_wready),
      .m_bresp    (m_bresp),
      .m_bvalid   (m_bvalid),
      .m_bready   (m_bready),
      .m_araddr   (m_araddr),
      .m_arvalid  (m_arvalid),
      .m_arready  (m_arready),
      .m_rdata    (m_rdata),
      .m_rresp    (m_rresp),
      .m_rvalid   (m_rvalid),
      .m_rready   (m_rready)
   );

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic w, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_wstrb = s;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      exp_t e;
      for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
      chk({tag, "_rsp_valid"}, rsp_valid, 1);
      if (rsp_valid) begin
         chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_resp"}, rsp_resp, e.resp);
            chk({tag, "_timeout"}, rsp_timeout, e.tmo);
         end
      end
   endtask

   task automatic ack(input string tag);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_rsp_cleared"}, rsp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit observed=running expected=finished");
      $fatal(1, "time limit");
   end

   initial begin
      int n;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid}, 0);
      chk("rst_readies", {m_bready, m_rready}, 0);
      chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_addr", {m_awaddr, m_araddr}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write, slave always ready: minimum latency
      m_awready = 1'b1;
      m_wready  = 1'b1;
      sb.push_back('{rdata: 32'h0, resp: 2'b00, tmo: 1'b0});
      send(1'b1, 32'h000, 32'h0000_0031, 4'hF);
      chk("w1_awvalid", m_awvalid, 1);
      chk("w1_wvalid", m_wvalid, 1);
      chk("w1_awaddr", m_awaddr, 32'h0);
      chk("w1_wdata", m_wdata, 32'h31);
      chk("w1_wstrb", m_wstrb, 4'hF);
      chk("w1_busy", busy, 1);
      chk("w1_cmd_ready", cmd_ready, 0);
      @(negedge clk);
      chk("w1_aw_drop", {m_awvalid, m_wvalid}, 0);
      chk("w1_bready", m_bready, 1);
      m_bvalid = 1'b1;
      m_bresp  = 2'b00;
      @(negedge clk);
      m_bvalid  = 1'b0;
      m_awready = 1'b0;
      m_wready  = 1'b0;
      chk("w1_rsp_cyc3", rsp_valid, 1);
      wait_rsp("w1");
      ack("w1");

      // Read with delayed arready and rvalid
      sb.push_back('{rdata: 32'd1920, resp: 2'b00, tmo: 1'b0});
      send(1'b0, 32'h00C, 32'h0, 4'h0);
      chk("r2_arvalid", m_arvalid, 1);
      chk("r2_araddr", m_araddr, 32'h00C);
      @(negedge clk);
      chk("r2_arvalid_hold", m_arvalid, 1);
      m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0;
      chk("r2_ar_drop", m_arvalid, 0);
      chk("r2_rready", m_rready, 1);
      @(negedge clk);
      m_rvalid = 1'b1;
      m_rdata  = 32'd1920;
      m_rresp  = 2'b00;
      @(negedge clk);
      m_rvalid = 1'b0;
      wait_rsp("r2");
      ack("r2");

      // Write with W accepted early and AW accepted late
      m_wready = 1'b1;
      sb.push_back('{rdata: 32'h0, resp: 2'b00, tmo: 1'b0});
      send(1'b1, 32'h010, 32'h0000_1234, 4'h3);
      chk("w3_both_valid", {m_awvalid, m_wvalid}, 2'b11);
      @(negedge clk);
      m_wready = 1'b0;
      chk("w3_w_drop", m_wvalid, 0);
      chk("w3_aw_hold2", m_awvalid, 1);
      @(negedge clk);
      chk("w3_aw_hold3", m_awvalid, 1);
      chk("w3_no_bready", m_bready, 0);
      @(negedge clk);
      chk("w3_aw_hold4", m_awvalid, 1);
      m_awready = 1'b1;
      @(negedge clk);
      m_awready = 1'b0;
      chk("w3_aw_drop", m_awvalid, 0);
      chk("w3_bready", m_bready, 1);
      m_bvalid = 1'b1;
      m_bresp  = 2'b00;
      @(negedge clk);
      m_bvalid = 1'b0;
      wait_rsp("w3");
      ack("w3");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("w3_single_rsp", rsp_valid, 0);
      end

      // Response back-pressure with a queued command behind it
      m_arready = 1'b1;
      sb.push_back('{rdata: 32'hDEAD_BEEF, resp: 2'b11, tmo: 1'b0});
      send(1'b0, 32'h020, 32'h0, 4'h0);
      chk("r4_arvalid", m_arvalid, 1);
      @(negedge clk);
      m_arready = 1'b0;
      chk("r4_rready", m_rready, 1);
      m_rvalid = 1'b1;
      m_rdata  = 32'hDEAD_BEEF;
      m_rresp  = 2'b11;
      @(negedge clk);
      m_rvalid = 1'b0;
      wait_rsp("r4");
      sb.push_back('{rdata: 32'h0, resp: 2'b10, tmo: 1'b0});
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h024;
      cmd_wdata = 32'h0000_A5A5;
      cmd_wstrb = 4'hF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("r4_hold_valid", rsp_valid, 1);
         chk("r4_hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
         chk("r4_hold_resp", rsp_resp, 2'b11);
         chk("r4_hold_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("r4_rsp_cleared", rsp_valid, 0);
      chk("r4_cmd_ready", cmd_ready, 1);
      m_awready = 1'b1;
      m_wready  = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("w4_awvalid", m_awvalid, 1);
      chk("w4_awaddr", m_awaddr, 32'h024);
      @(negedge clk);
      m_awready = 1'b0;
      m_wready  = 1'b0;
      chk("w4_bready", m_bready, 1);
      m_bvalid = 1'b1;
      m_bresp  = 2'b10;
      @(negedge clk);
      m_bvalid = 1'b0;
      wait_rsp("w4");
      ack("w4");

      // Watchdog: slave never accepts the read address
      sb.push_back('{rdata: 32'h0, resp: 2'b10, tmo: 1'b1});
      send(1'b0, 32'h030, 32'h0, 4'h0);
      n = 1;
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("t5_not_early", n >= TO, 1);
      chk("t5_not_late", n <= TO + 2, 1);
      wait_rsp("t5");
      chk("t5_arvalid_kept", m_arvalid, 1);
      chk("t5_busy", busy, 1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t5_rsp_hold", rsp_valid, 1);
         chk("t5_arvalid_hold", m_arvalid, 1);
      end
      ack("t5");
      chk("t5_busy_orphan", busy, 1);
      chk("t5_cmd_ready", cmd_ready, 0);
      chk("t5_arvalid_orphan", m_arvalid, 1);
      m_arready = 1'b1;
      @(negedge clk);
      m_arready = 1'b0;
      chk("t5_ar_drop", m_arvalid, 0);
      chk("t5_rready", m_rready, 1);
      chk("t5_busy_drain", busy, 1);
      m_rvalid = 1'b1;
      m_rdata  = 32'h0000_1234;
      m_rresp  = 2'b00;
      @(negedge clk);
      m_rvalid = 1'b0;
      chk("t5_rready_off", m_rready, 0);
      chk("t5_idle", busy, 0);
      chk("t5_cmd_ready_back", cmd_ready, 1);
      chk("t5_discarded", rsp_valid, 0);

      // Reset in the middle of a write
      sb.push_back('{rdata: 32'h0, resp: 2'b00, tmo: 1'b0});
      send(1'b1, 32'h040, 32'h0000_0077, 4'hF);
      chk("r6_awvalid", m_awvalid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("r6_valids", {m_awvalid, m_wvalid, m_arvalid}, 0);
      chk("r6_cmd_ready", cmd_ready, 1);
      chk("r6_busy", busy, 0);
      chk("r6_bready", m_bready, 0);
      sb.delete();
      @(negedge clk);
      rst_n    = 1'b1;
      m_bvalid = 1'b1;
      m_bresp  = 2'b10;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("r6_no_rsp", rsp_valid, 0);
         chk("r6_no_bready", m_bready, 0);
         chk("r6_idle", busy, 0);
      end
      m_bvalid = 1'b0;
      chk("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
